// File: rtl/branch_pkg.sv
// Shared branch definitions: funct3 encodings, resolver FSM states and the
// taken-decision decode reused by other branch logic.
package branch_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } funct3_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_e;

    function automatic logic decode_taken(input logic [2:0] funct3,
                                          input logic eq,
                                          input logic lt,
                                          input logic ltu);
        logic t;
        t = 1'b0;
        case (funct3)
            BEQ:     t = eq;
            BNE:     t = !eq;
            BLT:     t = lt;
            BGE:     t = !lt;
            BLTU:    t = ltu;
            BGEU:    t = !ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic is_illegal(input logic [2:0] funct3);
        return (funct3 == 3'b010) || (funct3 == 3'b011);
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational compare of one CHUNK-bit slice; top marks the slice that
// carries the operand sign bits.
module chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             top,
    output logic             ne,
    output logic             ltu,
    output logic             lt
);

    always_comb begin
        ne  = (a != b);
        ltu = (a < b);
        // Only the top slice sees the sign; differing signs decide outright.
        if (top && (a[CHUNK-1] != b[CHUNK-1]))
            lt = a[CHUNK-1];
        else
            lt = ltu;
    end

endmodule

// File: rtl/branch_resolve_seq.sv
// Sequential branch resolver: compares operands one chunk per cycle from the
// most significant chunk down, stopping at the first differing chunk.
module branch_resolve_seq
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] in_A,
    input  logic [XLEN-1:0] in_B,
    output logic            busy,
    output logic            done,
    output logic            breq,
    output logic            brlt,
    output logic            brltu,
    output logic            taken,
    output logic            illegal
);

    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    state_e          state, state_n;
    logic [IDXW-1:0] idx, idx_n;
    logic [XLEN-1:0] a_q, b_q;
    logic [2:0]      f3_q;
    logic            load, resolve;
    logic            c_ne, c_ltu, c_lt;

    chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .a   (a_q[idx*CHUNK +: CHUNK]),
        .b   (b_q[idx*CHUNK +: CHUNK]),
        .top (idx == IDX_TOP),
        .ne  (c_ne),
        .ltu (c_ltu),
        .lt  (c_lt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        load    = 1'b0;
        resolve = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    idx_n   = IDX_TOP;
                    state_n = CMP;
                end
            end
            CMP: begin
                if (c_ne || (idx == '0)) begin
                    resolve = 1'b1;
                    state_n = IDLE;
                end else begin
                    idx_n = idx - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == CMP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            done    <= 1'b0;
            breq    <= 1'b0;
            brlt    <= 1'b0;
            brltu   <= 1'b0;
            taken   <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done <= resolve;
            if (load) begin
                a_q  <= in_A;
                b_q  <= in_B;
                f3_q <= funct3;
            end
            // Equal chunks at resolution only happen at idx 0: operands equal.
            if (resolve) begin
                breq    <= !c_ne;
                brlt    <= c_ne && c_lt;
                brltu   <= c_ne && c_ltu;
                taken   <= decode_taken(f3_q, !c_ne, c_ne && c_lt, c_ne && c_ltu);
                illegal <= is_illegal(f3_q);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_seq.sv
// Self-checking bench for branch_resolve_seq: vector table plus scoreboard,
// with hand sequences for ignored start, back-to-back, and mid-op reset.
module tb_branch_resolve_seq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        int          lat;
        logic        eq;
        logic        lt;
        logic        ltu;
        logic        tk;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] in_A = '0;
    logic [31:0] in_B = '0;
    logic        busy, done, breq, brlt, brltu, taken, illegal;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   t_issue = 0;
    vec_t sbq[$];
    vec_t tbl[10];

    branch_resolve_seq #(.XLEN(32), .CHUNK(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .in_A    (in_A),
        .in_B    (in_B),
        .busy    (busy),
        .done    (done),
        .breq    (breq),
        .brlt    (brlt),
        .brltu   (brltu),
        .taken   (taken),
        .illegal (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives a request across the next posedge.
    task automatic issue(input vec_t v);
        in_A   = v.a;
        in_B   = v.b;
        funct3 = v.f3;
        start  = 1'b1;
        sbq.push_back(v);
        @(negedge clk);
        start   = 1'b0;
        t_issue = cyc;
    endtask

    task automatic wait_done(input string tag);
        vec_t e;
        int   n;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: done not seen within 60 cycles", tag);
        end else if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: done with empty scoreboard", tag);
        end else begin
            e = sbq.pop_front();
            chk({tag, " latency"}, 32'(cyc - t_issue), 32'(e.lat));
            chk({tag, " busy"},    {31'b0, busy},    32'h0);
            chk({tag, " breq"},    {31'b0, breq},    {31'b0, e.eq});
            chk({tag, " brlt"},    {31'b0, brlt},    {31'b0, e.lt});
            chk({tag, " brltu"},   {31'b0, brltu},   {31'b0, e.ltu});
            chk({tag, " taken"},   {31'b0, taken},   {31'b0, e.tk});
            chk({tag, " illegal"}, {31'b0, illegal}, {31'b0, e.ill});
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " busy"},    {31'b0, busy},    32'h0);
        chk({tag, " done"},    {31'b0, done},    32'h0);
        chk({tag, " results"}, {27'b0, breq, brlt, brltu, taken, illegal}, 32'h0);
    endtask

    initial begin
        //         a             b             f3      lat eq lt ltu tk ill
        tbl[0] = '{32'h1234_5678, 32'h1234_5678, 3'b000, 4, 1, 0, 0, 1, 0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1, 0, 1, 0, 1, 0};
        tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1, 0, 1, 0, 0, 0};
        tbl[3] = '{32'h8000_0005, 32'h8000_0007, 3'b111, 4, 0, 1, 1, 0, 0};
        tbl[4] = '{32'h0000_0001, 32'hFFFF_FFFF, 3'b101, 1, 0, 0, 1, 1, 0};
        tbl[5] = '{32'h1234_0000, 32'h1235_0000, 3'b001, 2, 0, 1, 1, 1, 0};
        tbl[6] = '{32'h7F00_0000, 32'h8000_0000, 3'b100, 1, 0, 0, 1, 0, 0};
        tbl[7] = '{32'h0000_1200, 32'h0000_1100, 3'b010, 3, 0, 0, 0, 0, 1};
        tbl[8] = '{32'h0000_0000, 32'h0000_0000, 3'b011, 4, 1, 0, 0, 0, 1};
        tbl[9] = '{32'hFFFF_FF80, 32'hFFFF_FF7F, 3'b110, 4, 0, 0, 0, 0, 0};

        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i]);
            chk($sformatf("v%0d busy after start", i), {31'b0, busy}, 32'h1);
            wait_done($sformatf("v%0d", i));
            @(negedge clk);
            chk($sformatf("v%0d done pulse", i), {31'b0, done}, 32'h0);
        end

        // Start pulses during busy must be ignored and not queued.
        issue(tbl[0]);
        in_A = 32'h0000_0001; in_B = 32'h0000_0002; funct3 = 3'b100; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("ignored no extra done %0d", i), {30'b0, busy, done}, 32'h0);
        end

        // Back-to-back: new start accepted in the done cycle.
        issue(tbl[1]);
        wait_done("b2b first");
        issue(tbl[7]);
        wait_done("b2b second");
        issue(tbl[4]);
        wait_done("b2b third");

        // Reset two cycles into an equal-operand compare, after a breq=1 result.
        @(negedge clk);
        issue(tbl[0]);
        wait_done("pre-reset");
        @(negedge clk);
        issue(tbl[8]);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_outputs_zero("mid-op reset");
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("post-reset no done %0d", i), {30'b0, busy, done}, 32'h0);
        end
        issue(tbl[3]);
        wait_done("after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
